// File: rtl/serial_cla_subtractor_if.sv
// Handshake and operand bundle for serial_cla_subtractor.
// The master drives operands and out_ready; the slave (the subtractor) returns the result.
interface serial_cla_subtractor_if #(
    parameter int N = 32
);
    logic         inValid;
    logic         inReady;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic         bin;
    logic         outValid;
    logic         outReady;
    logic [N-1:0] diff;
    logic         bout;
    logic         of;

    modport master (
        output inValid, in1, in2, bin, outReady,
        input  inReady, outValid, diff, bout, of
    );

    modport slave (
        input  inValid, in1, in2, bin, outReady,
        output inReady, outValid, diff, bout, of
    );
endinterface

// File: rtl/serial_cla_subtractor.sv
// Multi-cycle N-bit subtractor: one 4-bit carry-lookahead slice computes a + ~b + ~bin a nibble per cycle.
// Optional feature: define SUB_SATURATE_EN to clamp diff on signed overflow.
module serial_cla_subtractor #(
    parameter int N = 32
) (
    input logic                  clk,
    input logic                  rst,
    serial_cla_subtractor_if.slave bus
);
    localparam int M  = N / 4;
    localparam int KW = $clog2(M);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_bInv;
    logic          r_carry;
    logic [KW-1:0] r_k;
    logic [N-1:0]  r_diff;
    logic          r_bout;
    logic          r_of;

    logic [KW+1:0] w_base;
    logic [3:0]    w_nibA;
    logic [3:0]    w_nibB;
    logic [3:0]    w_g;
    logic [3:0]    w_p;
    logic [3:0]    w_c;
    logic          w_cout;
    logic [3:0]    w_sum;
    logic          w_last;
    logic          w_of;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (bus.inValid) w_nextState = RUN;
            RUN:     if (w_last) w_nextState = DONE;
            DONE:    if (bus.outReady) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Carry-lookahead slice over the current nibble; the carry is the inverted running borrow.
    always_comb begin
        w_base = {r_k, 2'b00};
        w_nibA = r_a[w_base +: 4];
        w_nibB = r_bInv[w_base +: 4];
        w_g    = w_nibA & w_nibB;
        w_p    = w_nibA ^ w_nibB;
        w_c[0] = r_carry;
        w_c[1] = w_g[0] | (w_p[0] & r_carry);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & r_carry);
        w_cout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
        w_sum  = w_p ^ w_c;
        w_last = (r_k == KW'(M - 1));
        w_of   = (r_a[N-1] != ~r_bInv[N-1]) && (w_sum[3] != r_a[N-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_bInv  <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_of    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.inValid) begin
                        r_a     <= bus.in1;
                        r_bInv  <= ~bus.in2;
                        r_carry <= ~bus.bin;
                        r_k     <= '0;
                    end
                end
                RUN: begin
                    r_diff[w_base +: 4] <= w_sum;
                    r_carry             <= w_cout;
                    r_k                 <= r_k + KW'(1);
                    if (w_last) begin
                        r_k    <= '0;
                        r_bout <= ~w_cout;
                        r_of   <= w_of;
`ifdef SUB_SATURATE_EN
                        // Clamp replaces the whole word, including the nibble written this cycle.
                        if (w_of) begin
                            r_diff <= r_a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.inReady  = (r_state == IDLE);
    assign bus.outValid = (r_state == DONE);
    assign bus.diff     = r_diff;
    assign bus.bout     = r_bout;
    assign bus.of       = r_of;
endmodule

// File: tb/tb_serial_cla_subtractor.sv
// Self-checking bench for serial_cla_subtractor at N=8: directed corner cases plus random operands
// against an arithmetic reference model.
module tb_serial_cla_subtractor;
    localparam int N = 8;
    localparam int M = N / 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    serial_cla_subtractor_if #(.N(N)) bus ();

    serial_cla_subtractor #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference: plain integer subtraction, borrow from sign of the full result.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi,
                         output logic [N-1:0] d, output logic bo, output logic o);
        int full;
        full = int'(a) - int'(b) - int'(bi);
        d    = full[N-1:0];
        bo   = (full < 0);
        o    = (a[N-1] != b[N-1]) && (d[N-1] != a[N-1]);
`ifdef SUB_SATURATE_EN
        if (o) d = a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
    endtask

    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi);
        int guard = 0;
        while (!bus.inReady && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) checkOutput("acceptTimeout", 32'd0, 32'd1);
        bus.in1     = a;
        bus.in2     = b;
        bus.bin     = bi;
        bus.inValid = 1'b1;
        @(posedge clk); #1;
        bus.inValid = 1'b0;
    endtask

    task automatic runOp(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi, input int hold);
        int cycles = 0;
        logic [N-1:0] expD;
        logic expBo, expO;
        applyStimulus(a, b, bi);
        checkOutput("inReadyInRun", 32'(bus.inReady), 32'd0);
        while (!bus.outValid && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("latency", cycles, M);
        model(a, b, bi, expD, expBo, expO);
        checkOutput("diff", 32'(bus.diff), 32'(expD));
        checkOutput("bout", 32'(bus.bout), 32'(expBo));
        checkOutput("of", 32'(bus.of), 32'(expO));
        // Hold the result with backpressure while offering a competing operand.
        for (int i = 0; i < hold; i++) begin
            bus.inValid = 1'b1;
            bus.in1     = ~a;
            bus.in2     = 8'h11;
            @(posedge clk); #1;
            checkOutput("holdValid", 32'(bus.outValid), 32'd1);
            checkOutput("holdReady", 32'(bus.inReady), 32'd0);
            checkOutput("holdDiff", 32'(bus.diff), 32'(expD));
            checkOutput("holdBout", 32'(bus.bout), 32'(expBo));
            checkOutput("holdOf", 32'(bus.of), 32'(expO));
        end
        bus.inValid  = 1'b0;
        bus.outReady = 1'b1;
        @(posedge clk); #1;
        bus.outReady = 1'b0;
        checkOutput("validDrop", 32'(bus.outValid), 32'd0);
        checkOutput("readyRise", 32'(bus.inReady), 32'd1);
    endtask

    initial begin
        bus.inValid  = 1'b0;
        bus.in1      = '0;
        bus.in2      = '0;
        bus.bin      = 1'b0;
        bus.outReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        $display("[TB] reset released");
        checkOutput("rstInReady", 32'(bus.inReady), 32'd1);
        checkOutput("rstOutValid", 32'(bus.outValid), 32'd0);
        checkOutput("rstDiff", 32'(bus.diff), 32'd0);
        checkOutput("rstBout", 32'(bus.bout), 32'd0);
        checkOutput("rstOf", 32'(bus.of), 32'd0);

        runOp(8'h05, 8'h03, 1'b0, 0);
        runOp(8'h03, 8'h05, 1'b0, 0);
        runOp(8'h80, 8'h01, 1'b0, 0);
        runOp(8'h7F, 8'hFF, 1'b0, 0);
        runOp(8'h00, 8'h00, 1'b1, 0);
        runOp(8'h00, 8'h01, 1'b0, 0);
        runOp(8'h05, 8'h03, 1'b0, 5);

        // Abort an operation after its first nibble; nothing may come out for it.
        applyStimulus(8'h42, 8'h17, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abortInReady", 32'(bus.inReady), 32'd1);
        checkOutput("abortOutValid", 32'(bus.outValid), 32'd0);
        begin
            int seen = 0;
            repeat (6) begin
                @(posedge clk); #1;
                if (bus.outValid) seen++;
            end
            checkOutput("abortNoResult", seen, 0);
        end

        for (int i = 0; i < 40; i++) begin
            runOp(N'($urandom), N'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
